// File: rtl/ao_nn_pipe_if.sv
// Handshake bundle for ao_nn_pipe: the input beat side (operands, mode, valid/ready)
// and the output side (result, valid/ready, completed-beat count).
interface ao_nn_pipe_if #(
  parameter int W     = 1,
  parameter int NTERM = 2,
  parameter int CNTW  = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         mode;
  logic [NTERM*W-1:0] i_a;
  logic [NTERM*W-1:0] i_b;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       q;
  logic [CNTW-1:0]    beat_cnt;

  modport slave (
    input  in_valid, mode, i_a, i_b, out_ready,
    output in_ready, out_valid, q, beat_cnt
  );

  modport master (
    output in_valid, mode, i_a, i_b, out_ready,
    input  in_ready, out_valid, q, beat_cnt
  );
endinterface

// File: rtl/ao_nn_pipe.sv
// Wide AO/OA/AOI/OAI reduction per bit lane, followed by an elastic valid/ready
// pipeline of STAGES slots and a saturating count of completed output beats.
module ao_nn_pipe #(
  parameter int W      = 1,
  parameter int NTERM  = 2,
  parameter int STAGES = 1,
  parameter int CNTW   = 16
) (
  input  logic         ck,
  input  logic         rst,
  ao_nn_pipe_if.slave  bus
);

  logic [W-1:0]      andOr;
  logic [W-1:0]      orAnd;
  logic [W-1:0]      result;
  logic [STAGES-1:0] adv;
  logic              outXfer;

  logic [STAGES-1:0] slotVld_q;
  logic [STAGES-1:0] slotVld_d;
  logic [W-1:0]      slotRes_q [STAGES];
  logic [W-1:0]      slotRes_d [STAGES];
  logic [CNTW-1:0]   beatCnt_q;
  logic [CNTW-1:0]   beatCnt_d;

  always_comb begin
    andOr = '0;
    orAnd = '1;
    for (int k = 0; k < NTERM; k++) begin
      andOr = andOr | (bus.i_a[k*W +: W] & bus.i_b[k*W +: W]);
      orAnd = orAnd & (bus.i_a[k*W +: W] | bus.i_b[k*W +: W]);
    end
    case (bus.mode)
      2'd0:    result = andOr;
      2'd1:    result = orAnd;
      2'd2:    result = ~andOr;
      default: result = ~orAnd;
    endcase
  end

  // A slot may take a new beat when it is empty or its own occupant moves on,
  // so a bubble anywhere gets filled even while the slots behind it stall.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ~slotVld_q[STAGES-1] | bus.out_ready;
    for (int s = STAGES - 2; s >= 0; s--) begin
      adv[s] = ~slotVld_q[s] | adv[s+1];
    end
  end

  assign outXfer = slotVld_q[STAGES-1] & bus.out_ready;

  // Result registers only load alongside a valid beat, keeping idle-cycle junk out.
  always_comb begin
    slotVld_d = slotVld_q;
    slotRes_d = slotRes_q;
    if (adv[0]) begin
      slotVld_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        slotRes_d[0] = result;
      end
    end
    for (int s = 1; s < STAGES; s++) begin
      if (adv[s]) begin
        slotVld_d[s] = slotVld_q[s-1];
        if (slotVld_q[s-1]) begin
          slotRes_d[s] = slotRes_q[s-1];
        end
      end
    end
  end

  always_comb begin
    beatCnt_d = beatCnt_q;
    if (outXfer && (beatCnt_q != '1)) begin
      beatCnt_d = beatCnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      slotVld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        slotRes_q[s] <= '0;
      end
      beatCnt_q <= '0;
    end else begin
      slotVld_q <= slotVld_d;
      slotRes_q <= slotRes_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = slotVld_q[STAGES-1];
  assign bus.q         = slotRes_q[STAGES-1];
  assign bus.beat_cnt  = beatCnt_q;

endmodule

// File: tb/tb_ao_nn_pipe.sv
// Scoreboard bench for ao_nn_pipe: a wide 3-stage instance and a 1-bit ao22-style
// 2-stage instance with a 4-bit counter, each with its own driver and monitor.
module tb_ao_nn_pipe;
  localparam int AW = 8, AN = 4, AS = 3, AC = 16;
  localparam int BW = 1, BN = 2, BS = 2, BC = 4;

  logic ck = 1'b0;
  logic rstA, rstB;
  always #5 ck = ~ck;

  ao_nn_pipe_if #(.W(AW), .NTERM(AN), .CNTW(AC)) ifA ();
  ao_nn_pipe_if #(.W(BW), .NTERM(BN), .CNTW(BC)) ifB ();

  ao_nn_pipe #(.W(AW), .NTERM(AN), .STAGES(AS), .CNTW(AC)) dutA (.ck(ck), .rst(rstA), .bus(ifA.slave));
  ao_nn_pipe #(.W(BW), .NTERM(BN), .STAGES(BS), .CNTW(BC)) dutB (.ck(ck), .rst(rstB), .bus(ifB.slave));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int xferA = 0, xferB = 0;
  int firstOutA = -1, lastOutA = -1;
  logic [63:0] expA [$];
  logic [63:0] expB [$];
  logic [63:0] popA, popB;

  always @(posedge ck) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: per bit, count how many terms have a&b set and how many have a|b set.
  function automatic logic [63:0] refModel(input int w, input int n, input logic [1:0] md,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    int andHits, orHits;
    r = '0;
    for (int j = 0; j < w; j++) begin
      andHits = 0;
      orHits  = 0;
      for (int k = 0; k < n; k++) begin
        if (a[k*w+j] & b[k*w+j]) andHits++;
        if (a[k*w+j] | b[k*w+j]) orHits++;
      end
      case (md)
        2'd0:    r[j] = (andHits > 0);
        2'd1:    r[j] = (orHits == n);
        2'd2:    r[j] = (andHits == 0);
        default: r[j] = (orHits != n);
      endcase
    end
    return r;
  endfunction

  always @(negedge ck) begin
    if (!rstA && ifA.out_valid && ifA.out_ready) begin
      if (firstOutA < 0) firstOutA = cyc;
      lastOutA = cyc;
      xferA++;
      if (expA.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedOutA: got q=%0h expected no output", ifA.q);
      end else begin
        popA = expA.pop_front();
        checkOutput("qA", 64'(ifA.q), popA);
      end
    end
  end

  always @(negedge ck) begin
    if (!rstB && ifB.out_valid && ifB.out_ready) begin
      xferB++;
      if (expB.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedOutB: got q=%0h expected no output", ifB.q);
      end else begin
        popB = expB.pop_front();
        checkOutput("qB", 64'(ifB.q), popB);
      end
    end
  end

  task automatic applyStimulusA(input bit vld, input logic [1:0] md, input logic [31:0] a,
                                input logic [31:0] b, input bit ordy, output bit acc);
    @(posedge ck);
    #1;
    ifA.in_valid  = vld;
    ifA.mode      = md;
    ifA.i_a       = a;
    ifA.i_b       = b;
    ifA.out_ready = ordy;
    @(negedge ck);
    acc = vld && ifA.in_ready;
    #1;
  endtask

  task automatic applyStimulusB(input bit vld, input logic [1:0] md, input logic [1:0] a,
                                input logic [1:0] b, input bit ordy, output bit acc);
    @(posedge ck);
    #1;
    ifB.in_valid  = vld;
    ifB.mode      = md;
    ifB.i_a       = a;
    ifB.i_b       = b;
    ifB.out_ready = ordy;
    @(negedge ck);
    acc = vld && ifB.in_ready;
    #1;
  endtask

  task automatic drainA();
    bit acc;
    int n = 0;
    while (expA.size() != 0 && n < 40) begin
      applyStimulusA(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, acc);
      n++;
    end
    if (expA.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drainA: got %0d pending expected 0", expA.size());
      expA.delete();
    end
    applyStimulusA(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, acc);
  endtask

  task automatic drainB();
    bit acc;
    int n = 0;
    while (expB.size() != 0 && n < 40) begin
      applyStimulusB(1'b0, 2'd0, 2'd0, 2'd0, 1'b1, acc);
      n++;
    end
    if (expB.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drainB: got %0d pending expected 0", expB.size());
      expB.delete();
    end
    applyStimulusB(1'b0, 2'd0, 2'd0, 2'd0, 1'b1, acc);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int firstAcc;
    logic [1:0] md;
    logic [31:0] ra, rb;
    logic [3:0] v;
    logic [63:0] qHold;

    rstA = 1'b1;
    rstB = 1'b1;
    ifA.in_valid = 0; ifA.mode = 0; ifA.i_a = 0; ifA.i_b = 0; ifA.out_ready = 0;
    ifB.in_valid = 0; ifB.mode = 0; ifB.i_a = 0; ifB.i_b = 0; ifB.out_ready = 0;
    repeat (2) @(posedge ck);
    @(negedge ck);
    checkOutput("rstA_out_valid", 64'(ifA.out_valid), 64'd0);
    checkOutput("rstA_q", 64'(ifA.q), 64'd0);
    checkOutput("rstA_beat_cnt", 64'(ifA.beat_cnt), 64'd0);
    checkOutput("rstB_out_valid", 64'(ifB.out_valid), 64'd0);
    @(posedge ck);
    #1;
    rstA = 1'b0;
    rstB = 1'b0;
    #1;
    checkOutput("rstA_in_ready", 64'(ifA.in_ready), 64'd1);
    checkOutput("rstB_in_ready", 64'(ifB.in_ready), 64'd1);

    // 10 back-to-back beats through the 3-stage instance
    firstAcc = -1;
    for (int i = 0; i < 10; i++) begin
      md = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      applyStimulusA(1'b1, md, ra, rb, 1'b1, acc);
      if (acc) begin
        if (firstAcc < 0) firstAcc = cyc + 1;
        expA.push_back(refModel(AW, AN, md, 64'(ra), 64'(rb)));
      end
    end
    drainA();
    checkOutput("latencyA", 64'(firstOutA), 64'(firstAcc + AS - 1));
    checkOutput("noBubbleA", 64'(lastOutA - firstOutA), 64'd9);
    checkOutput("beatCntA10", 64'(ifA.beat_cnt), 64'd10);

    // Directed wide-lane cases: only term 0 has its low byte set
    applyStimulusA(1'b1, 2'd1, 32'h0000_00FF, 32'h0000_00FF, 1'b1, acc);
    if (acc) expA.push_back(64'h00);
    applyStimulusA(1'b1, 2'd3, 32'h0000_00FF, 32'h0000_00FF, 1'b1, acc);
    if (acc) expA.push_back(64'hFF);
    applyStimulusA(1'b1, 2'd0, 32'h0000_00FF, 32'h0000_00FF, 1'b1, acc);
    if (acc) expA.push_back(64'hFF);
    checkOutput("directedAccepted", 64'(expA.size()), 64'd3);
    drainA();

    for (int i = 0; i < 300; i++) begin
      md = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      applyStimulusA(1'($urandom_range(0, 1)), md, ra, rb, ($urandom_range(0, 3) != 0), acc);
      if (acc) expA.push_back(refModel(AW, AN, md, 64'(ra), 64'(rb)));
    end
    drainA();
    checkOutput("beatCntArand", 64'(ifA.beat_cnt), 64'(xferA));
    checkOutput("idleA_out_valid", 64'(ifA.out_valid), 64'd0);

    // Reset with two beats stalled in flight
    applyStimulusA(1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, acc);
    if (acc) expA.push_back(64'hFF);
    applyStimulusA(1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, acc);
    if (acc) expA.push_back(64'hFF);
    applyStimulusA(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, acc);
    applyStimulusA(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, acc);
    checkOutput("preRstA_out_valid", 64'(ifA.out_valid), 64'd1);
    rstA = 1'b1;
    #1;
    checkOutput("midRstA_out_valid", 64'(ifA.out_valid), 64'd0);
    checkOutput("midRstA_q", 64'(ifA.q), 64'd0);
    checkOutput("midRstA_beat_cnt", 64'(ifA.beat_cnt), 64'd0);
    expA.delete();
    xferA = 0;
    repeat (2) @(posedge ck);
    #1;
    rstA = 1'b0;
    #1;
    checkOutput("postRstA_in_ready", 64'(ifA.in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      applyStimulusA(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, acc);
    end
    checkOutput("postRstA_out_valid", 64'(ifA.out_valid), 64'd0);
    checkOutput("postRstA_beat_cnt", 64'(ifA.beat_cnt), 64'd0);

    // ao22 truth-table sweep on the 1-bit instance; v = {b1,a1,b0,a0}
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      applyStimulusB(1'b1, 2'd0, {v[2], v[0]}, {v[3], v[1]}, 1'b1, acc);
      if (acc) expB.push_back(64'((v[0] & v[1]) | (v[2] & v[3])));
      if (i == 7) begin
        drainB();
        checkOutput("beatCntB8", 64'(ifB.beat_cnt), 64'd8);
      end
    end
    drainB();
    checkOutput("beatCntBsat16", 64'(ifB.beat_cnt), 64'd15);

    // Backpressure: two beats fill the 2-stage instance, the third is refused
    applyStimulusB(1'b1, 2'd0, 2'b01, 2'b01, 1'b0, acc);
    if (acc) expB.push_back(64'd1);
    applyStimulusB(1'b1, 2'd2, 2'b01, 2'b01, 1'b0, acc);
    if (acc) expB.push_back(64'd0);
    applyStimulusB(1'b1, 2'd0, 2'b11, 2'b11, 1'b0, acc);
    checkOutput("bpFullRefused", 64'(acc), 64'd0);
    qHold = 64'(ifB.q);
    applyStimulusB(1'b1, 2'd0, 2'b11, 2'b11, 1'b0, acc);
    applyStimulusB(1'b1, 2'd0, 2'b11, 2'b11, 1'b0, acc);
    checkOutput("bpHoldValid", 64'(ifB.out_valid), 64'd1);
    checkOutput("bpHoldQ", 64'(ifB.q), qHold);
    checkOutput("bpHoldQval", qHold, 64'd1);
    applyStimulusB(1'b1, 2'd1, 2'b10, 2'b01, 1'b1, acc);
    checkOutput("bpSimulInOut", 64'(acc), 64'd1);
    if (acc) expB.push_back(64'd1);
    applyStimulusB(1'b1, 2'd0, 2'b11, 2'b11, 1'b0, acc);
    checkOutput("bpStillFull", 64'(acc), 64'd0);
    drainB();

    for (int i = 0; i < 40; i++) begin
      md = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      applyStimulusB(1'($urandom_range(0, 1)), md, ra[1:0], rb[1:0], ($urandom_range(0, 2) != 0), acc);
      if (acc) expB.push_back(refModel(BW, BN, md, 64'(ra[1:0]), 64'(rb[1:0])));
    end
    drainB();
    checkOutput("beatCntBsatFinal", 64'(ifB.beat_cnt), 64'((xferB > 15) ? 15 : xferB));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
